// File: rtl/keypad_scanner.sv
// Active column scanner for a 4x4 active-low matrix keypad.
// Drives one column low at a time, synchronizes the row lines, debounces
// press and release of the first key found, and reports its code with a
// single-cycle valid strobe. The column stays frozen while a key is being
// qualified, held or released, so other columns are ignored until then.
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_SCAN     | walking the columns, sampling rows at the end of each dwell
// ST_DEBOUNCE | candidate found, waiting for it to stay low long enough
// ST_PRESSED  | key accepted and still down
// ST_RELEASE  | candidate row high, waiting for a clean release
module keypad_scanner #(
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE_CNT = 8,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] shift_col,
    output logic [3:0] key_value,
    output logic       key_valid,
    output logic       key_held,
    output logic [3:0] debounced
);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    // Dwell reload gives SCAN_DIV cycles per column; the debounce reload is
    // two short because the detecting sample (or the first high sample in
    // PRESSED) already counts as one stable cycle and the last one is the
    // terminal-count cycle itself.
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DB_LOAD    = CNT_W'(DEBOUNCE_CNT - 2);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [3:0]       row_meta;
    state_t           state_q, state_d;
    logic [1:0]       col_q, col_d;
    logic [1:0]       cand_q, cand_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic [CNT_W-1:0] db_q, db_d;

    logic [3:0]       shift_col_d;
    logic [3:0]       key_value_d;
    logic             key_valid_d;
    logic             key_held_d;

    logic             dwell_tc;
    logic             db_tc;
    logic             any_low;
    logic             cand_high;
    logic [1:0]       low_row;
    logic [1:0]       col_next;

    assign dwell_tc  = (dwell_q == '0);
    assign db_tc     = (db_q == '0);
    assign any_low   = ~&debounced;
    assign cand_high = debounced[cand_q];
    assign col_next  = col_q + 2'd1;

    // Lowest-index low row wins when several rows are pressed together.
    always_comb begin
        low_row = 2'd3;
        casez (debounced)
            4'b???0: low_row = 2'd0;
            4'b??01: low_row = 2'd1;
            4'b?011: low_row = 2'd2;
            default: low_row = 2'd3;
        endcase
    end

    // Two-flop synchronizer for the asynchronous row lines.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_meta  <= 4'hF;
            debounced <= 4'hF;
        end else begin
            row_meta  <= row;
            debounced <= row_meta;
        end
    end

    // State register together with column, candidate and timer state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_SCAN;
            col_q   <= 2'd0;
            cand_q  <= 2'd0;
            dwell_q <= DWELL_LOAD;
            db_q    <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            cand_q  <= cand_d;
            dwell_q <= dwell_d;
            db_q    <= db_d;
        end
    end

    // Next-state and timer logic.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        cand_d  = cand_q;
        dwell_d = dwell_q;
        db_d    = db_q;
        case (state_q)
            ST_SCAN: begin
                if (dwell_tc) begin
                    if (any_low) begin
                        cand_d  = low_row;
                        db_d    = DB_LOAD;
                        state_d = ST_DEBOUNCE;
                    end else begin
                        col_d   = col_next;
                        dwell_d = DWELL_LOAD;
                    end
                end else begin
                    dwell_d = dwell_q - CNT_ONE;
                end
            end
            ST_DEBOUNCE: begin
                if (cand_high) begin
                    state_d = ST_SCAN;
                    col_d   = col_next;
                    dwell_d = DWELL_LOAD;
                end else if (db_tc) begin
                    state_d = ST_PRESSED;
                end else begin
                    db_d = db_q - CNT_ONE;
                end
            end
            ST_PRESSED: begin
                if (cand_high) begin
                    db_d    = DB_LOAD;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!cand_high) begin
                    state_d = ST_PRESSED;
                end else if (db_tc) begin
                    state_d = ST_SCAN;
                    col_d   = col_next;
                    dwell_d = DWELL_LOAD;
                end else begin
                    db_d = db_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_SCAN;
                col_d   = 2'd0;
                dwell_d = DWELL_LOAD;
            end
        endcase
    end

    // Output decode, evaluated on the next state so the registered outputs
    // line up with the state they describe.
    always_comb begin
        shift_col_d = ~(4'b0001 << col_d);
        key_valid_d = (state_q == ST_DEBOUNCE) && (state_d == ST_PRESSED);
        key_value_d = key_valid_d ? {col_q, cand_q} : key_value;
        key_held_d  = (state_d == ST_PRESSED) || (state_d == ST_RELEASE);
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_col <= 4'b1110;
            key_value <= 4'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            shift_col <= shift_col_d;
            key_value <= key_value_d;
            key_valid <= key_valid_d;
            key_held  <= key_held_d;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad model drives the rows from the
// scanned columns, and a run-length reference model predicts every output.
module tb_keypad_scanner;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 8;

    localparam int M_SCAN      = 0;
    localparam int M_CONFIRM   = 1;
    localparam int M_HELD      = 2;
    localparam int M_RELEASING = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] row;
    logic [3:0] shift_col;
    logic [3:0] key_value;
    logic       key_valid;
    logic       key_held;
    logic [3:0] debounced;

    logic       key_down [16];

    int n_tests = 0;
    int n_fail  = 0;
    int pulses  = 0;
    logic [3:0] last_val = 4'd0;

    // reference model state
    logic [3:0] m_s1, m_s2;
    int         m_col, m_phase, m_mode, m_cand, m_run;
    logic [3:0] m_value;
    logic       m_valid, m_held;

    keypad_scanner #(
        .SCAN_DIV    (SCAN_DIV),
        .DEBOUNCE_CNT(DEBOUNCE_CNT),
        .CNT_W       (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .row      (row),
        .shift_col(shift_col),
        .key_value(key_value),
        .key_valid(key_valid),
        .key_held (key_held),
        .debounced(debounced)
    );

    always #5 clk = ~clk;

    // keypad: a pressed key pulls its row low while its column is driven low
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (key_down[4*c+r] && (shift_col[c] == 1'b0)) row[r] = 1'b0;
    end

    task automatic check_eq(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = 4'hF; m_s2 = 4'hF;
        m_col = 0; m_phase = 0; m_mode = M_SCAN; m_cand = 0; m_run = 0;
        m_value = 4'd0; m_valid = 1'b0; m_held = 1'b0;
    endtask

    function automatic int lowest_low(input logic [3:0] d);
        for (int i = 0; i < 4; i++) if (!d[i]) return i;
        return 0;
    endfunction

    // one clock edge of the reference behaviour; r is the row value at the edge
    task automatic model_edge(input logic [3:0] r);
        logic [3:0] d;
        d = m_s2;
        m_valid = 1'b0;
        case (m_mode)
            M_SCAN: begin
                if (m_phase == SCAN_DIV - 1) begin
                    if (d == 4'hF) begin
                        m_col = (m_col + 1) % 4;
                        m_phase = 0;
                    end else begin
                        m_cand = lowest_low(d);
                        m_run = 1;
                        m_mode = M_CONFIRM;
                    end
                end else begin
                    m_phase++;
                end
            end
            M_CONFIRM: begin
                if (d[m_cand] == 1'b0) begin
                    m_run++;
                    if (m_run == DEBOUNCE_CNT) begin
                        m_mode = M_HELD;
                        m_value = 4'(4 * m_col + m_cand);
                        m_valid = 1'b1;
                        m_held = 1'b1;
                    end
                end else begin
                    m_mode = M_SCAN;
                    m_col = (m_col + 1) % 4;
                    m_phase = 0;
                end
            end
            M_HELD: begin
                if (d[m_cand]) begin
                    m_run = 1;
                    m_mode = M_RELEASING;
                end
            end
            default: begin
                if (d[m_cand]) begin
                    m_run++;
                    if (m_run == DEBOUNCE_CNT) begin
                        m_mode = M_SCAN;
                        m_held = 1'b0;
                        m_col = (m_col + 1) % 4;
                        m_phase = 0;
                    end
                end else begin
                    m_mode = M_HELD;
                end
            end
        endcase
        m_s2 = m_s1;
        m_s1 = r;
    endtask

    task automatic check_outputs();
        logic [3:0] one;
        logic [3:0] exp_col;
        one = 4'b0001;
        exp_col = ~(one << m_col);
        check_eq("shift_col", shift_col, exp_col);
        check_eq("key_value", key_value, m_value);
        check_eq("key_valid", {3'b000, key_valid}, {3'b000, m_valid});
        check_eq("key_held", {3'b000, key_held}, {3'b000, m_held});
        check_eq("debounced", debounced, m_s2);
    endtask

    task automatic step();
        logic [3:0] r;
        logic       rs;
        @(negedge clk);
        r = row;
        rs = reset;
        @(posedge clk);
        #1;
        if (!rs) model_reset();
        else model_edge(r);
        check_outputs();
        if (key_valid) begin
            pulses++;
            last_val = key_value;
        end
    endtask

    task automatic wait_mode(input int mode, input int budget);
        int k;
        k = 0;
        while (m_mode != mode && k < budget) begin
            step();
            k++;
        end
        if (m_mode != mode) check_eq("wait_timeout", 4'(m_mode), 4'(mode));
    endtask

    task automatic clear_keys();
        for (int i = 0; i < 16; i++) key_down[i] = 1'b0;
    endtask

    task automatic set_key(input int c, input int r, input logic v);
        key_down[4*c+r] = v;
    endtask

    task automatic async_reset_pulse(input int cycles);
        reset = 1'b0;
        #1;
        check_eq("rst_key_held", {3'b000, key_held}, 4'd0);
        check_eq("rst_key_value", key_value, 4'd0);
        check_eq("rst_shift_col", shift_col, 4'b1110);
        model_reset();
        repeat (cycles) step();
        reset = 1'b1;
    endtask

    initial begin
        logic [15:0] chosen;
        int hold;
        clear_keys();
        model_reset();

        // 1: reset then idle scanning
        repeat (10) step();
        check_eq("t1_rst_col", shift_col, 4'b1110);
        reset = 1'b1;
        repeat (40) step();
        check_eq("t1_pulses", 4'(pulses), 4'd0);

        // 3: press bounce abandoned before acceptance
        pulses = 0;
        set_key(1, 2, 1'b1);
        wait_mode(M_CONFIRM, 100);
        repeat (2) step();
        clear_keys();
        repeat (30) step();
        check_eq("t3_pulses", 4'(pulses), 4'd0);
        check_eq("t3_value", key_value, 4'd0);

        // 2: single key (col2,row1)
        repeat ($urandom_range(0, 15)) step();
        pulses = 0;
        set_key(2, 1, 1'b1);
        repeat (60) step();
        clear_keys();
        repeat (40) step();
        check_eq("t2_pulses", 4'(pulses), 4'd1);
        check_eq("t2_value", last_val, 4'd9);

        // 4: two rows in the same column, lowest row wins
        pulses = 0;
        set_key(1, 3, 1'b1);
        set_key(1, 1, 1'b1);
        repeat (60) step();
        clear_keys();
        repeat (40) step();
        check_eq("t4_pulses", 4'(pulses), 4'd1);
        check_eq("t4_value", last_val, 4'd5);

        // 5: release bounce absorbed
        pulses = 0;
        set_key(3, 0, 1'b1);
        wait_mode(M_HELD, 100);
        repeat (10) step();
        clear_keys();
        repeat (3) step();
        set_key(3, 0, 1'b1);
        repeat (2) step();
        check_eq("t5_held", {3'b000, key_held}, 4'd1);
        clear_keys();
        repeat (40) step();
        check_eq("t5_pulses", 4'(pulses), 4'd1);
        check_eq("t5_value", last_val, 4'd12);
        check_eq("t5_held_end", {3'b000, key_held}, 4'd0);

        // 6: async reset while pressed, then a fresh press
        pulses = 0;
        set_key(0, 2, 1'b1);
        wait_mode(M_HELD, 100);
        repeat (5) step();
        clear_keys();
        async_reset_pulse(3);
        repeat (2) step();
        pulses = 0;
        set_key(0, 2, 1'b1);
        repeat (40) step();
        clear_keys();
        repeat (30) step();
        check_eq("t6_pulses", 4'(pulses), 4'd1);
        check_eq("t6_value", last_val, 4'd2);

        // random presses with dropouts and occasional resets
        for (int it = 0; it < 40; it++) begin
            chosen = 16'd0;
            chosen[$urandom_range(0, 15)] = 1'b1;
            if ($urandom_range(0, 2) == 0) chosen[$urandom_range(0, 15)] = 1'b1;
            hold = $urandom_range(1, 45);
            for (int i = 0; i < hold; i++) begin
                logic drop;
                drop = ($urandom_range(0, 9) == 0);
                for (int k = 0; k < 16; k++) key_down[k] = chosen[k] && !drop;
                step();
                if ($urandom_range(0, 299) == 0) async_reset_pulse(2);
            end
            clear_keys();
            repeat ($urandom_range(0, 30)) step();
        end
        repeat (30) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Active scanning front end for the 4x4 matrix keypad on the vending machine.
- Drives the column lines (shift_col) one at a time, active-low, and samples the row lines.
- Debounces both press and release, then emits a 4-bit key code with a one-cycle valid strobe.
- Sits between the keypad pins and the vending_machine key/price logic, which consumes key_value and key_valid.

Parameters:
- SCAN_DIV, 4: clock cycles each column is driven low before advancing; must be >= 4.
- DEBOUNCE_CNT, 8: consecutive stable cycles required to accept a press or a release; must be >= 2.
- CNT_W, 8: width of the internal dwell and debounce counters; must hold max(SCAN_DIV, DEBOUNCE_CNT).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- row  input  4  keypad row lines, active-low, asynchronous to clk.
- shift_col  output  4  column drive, one-hot-low: exactly one bit is 0 at all times.
- key_value  output  4  code of the last accepted key: 4*col_index + row_index.
- key_valid  output  1  one-cycle pulse when a new debounced press is accepted.
- key_held  output  1  high while an accepted key is still pressed, including the release-debounce window.
- debounced  output  4  synchronized row vector (second sync flop); diagnostic only.

Behaviour:
- Reset (reset=0, asynchronous):
  - shift_col=4'b1110, key_value=0, key_valid=0, key_held=0, debounced=4'b1111.
  - All counters clear; state=SCAN with column index 0.
  - Reset asserted in any state forces these values immediately.
- Synchronizer: row passes through a 2-flop synchronizer. debounced is the second flop output. All decisions use debounced, so there is 2 cycles of input latency.
- Column index 0 corresponds to shift_col=1110, index 3 to 0111. Row index r corresponds to row bit r being low.
- SCAN:
  - Drive the current column for SCAN_DIV cycles.
  - On the last dwell cycle, sample debounced.
  - If all bits are 1: advance the column (3 wraps to 0) and reset the dwell counter.
  - If any bit is 0: latch the candidate (col, lowest-index low row), hold the column, clear the debounce counter, go to DEBOUNCE.
  - Multiple low rows: the lowest row index wins.
- DEBOUNCE (column frozen):
  - Each cycle, if the candidate row bit is 0, increment the counter.
  - When the count reaches DEBOUNCE_CNT-1: go to PRESSED; key_value <= candidate code and key_valid=1 in that same cycle.
  - If the candidate row bit is 1 in any cycle: abandon the candidate (no pulse), return to SCAN, advance to the next column.
- PRESSED:
  - key_held=1; key_valid is 0 after the entry cycle.
  - When the candidate row bit goes 1: clear the counter, go to RELEASE.
- RELEASE:
  - key_held stays 1.
  - Candidate row bit 1 for DEBOUNCE_CNT consecutive cycles: key_held=0, go to SCAN with the next column.
  - Candidate row bit 0 before that: return to PRESSED with no new key_valid (release bounce is absorbed).
- key_value holds its value until the next accepted press. It is never cleared except by reset.
- At most one key_valid per physical press. Holding a key never auto-repeats.
- Keys in other columns are invisible while the column is frozen (DEBOUNCE/PRESSED/RELEASE), so there is no rollover.
- Press latency: with the key stable, key_valid fires DEBOUNCE_CNT cycles after the sample that detected it. The sample occurs at most 2 + SCAN_DIV*4 cycles after the press.
- All outputs are registered. shift_col never has zero or two low bits, including across reset release.

Test Plan:
- The bench keypad model drives row[r]=0 only while shift_col[c]=0 for the pressed key (c,r). Parameters: SCAN_DIV=4, DEBOUNCE_CNT=8.
1. Reset held 10 cycles, then released with no keys -> shift_col=1110 during reset; thereafter the sequence 1110,1101,1011,0111,1110 at 4 cycles each; key_valid never asserts.
2. Press key (col2,row1) for 60 cycles -> exactly one key_valid pulse with key_value=4'd9; shift_col frozen at 1011; key_held falls 8 cycles after release; scanning resumes at 0111.
3. Press bounce: row low for 3 cycles after detection, then high -> no key_valid; key_value unchanged (0); scanning continues at the next column.
4. Keys (col1,row3) and (col1,row1) pressed together -> key_value=4'd5 (row1 wins), one pulse.
5. Release bounce: after acceptance of (col3,row0), release for 3 cycles, re-press for 2, then release -> a single key_valid, key_value=4'd12; key_held stays 1 until 8 clean high cycles.
6. Reset asserted mid-PRESSED -> same cycle: key_held=0, key_value=0, shift_col=1110; after release, scanning restarts at column 0, and re-pressing the held key yields a fresh pulse.
